// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared defaults, pointer type and clog2 helper for sync_fifo_gen
package sync_fifo_pkg;

  // Default geometry: one Ascon state word per entry, 16 entries.
  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 4;
  localparam int PTR_W_DEF  = ADDR_W_DEF + 1;

  // Pointer for the default geometry: ADDR_W address bits plus a wrap bit.
  typedef logic [PTR_W_DEF-1:0] ptr_t;

  // Ceiling log2 for elaboration-time sizing; returns 0 for values <= 1.
  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - DEPTH x DATA_W storage, synchronous write, asynchronous read
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = 1 << ADDR_W_DEF,
  localparam int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // Storage is deliberately not reset: flush and reset only move pointers.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port: store the accepted word at the write address.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_gen.sv
// rtl/sync_fifo_gen.sv - parametrised single-clock FIFO; SYNC_FIFO_FWFT_EN selects first-word-fall-through read
module sync_fifo_gen
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              flush,
  input  logic              err_clr,
  input  logic [ADDR_W:0]   almst_full_thr,
  input  logic [ADDR_W:0]   almst_empty_thr,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W:0]   data_count,
  output logic              empty,
  output logic              full,
  output logic              almst_empty,
  output logic              almst_full,
  output logic              ovf_err,
  output logic              udf_err
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              ovf_err_q, ovf_err_d;
  logic              udf_err_q, udf_err_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] ram_rdata;

  // Occupancy and all status flags come from registered pointers only.
  assign data_count  = wr_ptr_q - rd_ptr_q;
  assign empty       = (data_count == '0);
  assign full        = (data_count == DEPTH_P);
  assign almst_full  = (data_count >= almst_full_thr);
  assign almst_empty = (data_count <= almst_empty_thr);
  assign ovf_err     = ovf_err_q;
  assign udf_err     = udf_err_q;

  // Acceptance, pointer advance and sticky error next-state; flush overrides requests.
  always_comb begin
    wr_acc    = wr_en && !full  && !flush;
    rd_acc    = rd_en && !empty && !flush;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ovf_err_d = ovf_err_q;
    udf_err_d = udf_err_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_P;
      if (rd_acc) rd_ptr_d = rd_ptr_q + ONE_P;
    end
    // Clear first so a same-cycle rejection wins.
    if (err_clr) begin
      ovf_err_d = 1'b0;
      udf_err_d = 1'b0;
    end
    if (wr_en && full  && !flush) ovf_err_d = 1'b1;
    if (rd_en && empty && !flush) udf_err_d = 1'b1;
  end

  // Pointer and error flag registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_err_q <= 1'b0;
      udf_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_err_q <= ovf_err_d;
      udf_err_q <= udf_err_d;
    end
  end

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented as soon as the FIFO is non-empty; rd_en just pops it.
  assign data_out = empty ? '0 : ram_rdata;
`else
  logic [DATA_W-1:0] data_out_q, data_out_d;

  // Load the head word on an accepted read, hold otherwise (including flush).
  always_comb begin
    data_out_d = data_out_q;
    if (rd_acc) data_out_d = ram_rdata;
  end

  // Registered read data.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) data_out_q <= '0;
    else          data_out_q <= data_out_d;
  end

  assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_sync_fifo_gen.sv
// tb/tb_sync_fifo_gen.sv - randomized self-checking bench for sync_fifo_gen against a queue model
module tb_sync_fifo_gen;

  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          n_reset;
  logic [DW-1:0] data_in;
  logic          wr_en, rd_en, flush, err_clr;
  logic [AW:0]   almst_full_thr, almst_empty_thr;
  logic [DW-1:0] data_out;
  logic [AW:0]   data_count;
  logic          empty, full, almst_empty, almst_full, ovf_err, udf_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic          m_ovf, m_udf;
  logic [DW-1:0] m_dout;

  sync_fifo_gen #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk             (clk),
    .n_reset         (n_reset),
    .data_in         (data_in),
    .wr_en           (wr_en),
    .rd_en           (rd_en),
    .flush           (flush),
    .err_clr         (err_clr),
    .almst_full_thr  (almst_full_thr),
    .almst_empty_thr (almst_empty_thr),
    .data_out        (data_out),
    .data_count      (data_count),
    .empty           (empty),
    .full            (full),
    .almst_empty     (almst_empty),
    .almst_full      (almst_full),
    .ovf_err         (ovf_err),
    .udf_err         (udf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_dout = '0;
  endtask

  task automatic check_outputs();
    int n;
    logic [DW-1:0] exp_dout;
    n = mq.size();
`ifdef SYNC_FIFO_FWFT_EN
    exp_dout = (n == 0) ? '0 : mq[0];
`else
    exp_dout = m_dout;
`endif
    check("data_count",  64'(data_count),  64'(n));
    check("empty",       64'(empty),       64'(n == 0));
    check("full",        64'(full),        64'(n == DEPTH));
    check("almst_full",  64'(almst_full),  64'(n >= int'(almst_full_thr)));
    check("almst_empty", 64'(almst_empty), 64'(n <= int'(almst_empty_thr)));
    check("ovf_err",     64'(ovf_err),     64'(m_ovf));
    check("udf_err",     64'(udf_err),     64'(m_udf));
    check("data_out",    data_out,         exp_dout);
  endtask

  // One clock with the currently driven inputs; model advances by FIFO rules.
  task automatic cycle();
    bit            fl, w, r, c;
    logic [DW-1:0] d;
    int            n;
    fl = flush; w = wr_en; r = rd_en; c = err_clr; d = data_in;
    n  = mq.size();
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (r && n > 0) begin
`ifdef SYNC_FIFO_FWFT_EN
        mq.delete(0);
`else
        m_dout = mq.pop_front();
`endif
      end
      if (w && n < DEPTH) mq.push_back(d);
    end
    if (c) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    if (!fl && w && n == DEPTH) m_ovf = 1'b1;
    if (!fl && r && n == 0)     m_udf = 1'b1;
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_write(input logic [DW-1:0] d);
    idle_inputs(); wr_en = 1'b1; data_in = d; cycle();
  endtask

  task automatic do_read();
    idle_inputs(); rd_en = 1'b1; cycle();
  endtask

  initial begin
    n_reset = 1'b0;
    data_in = '0;
    idle_inputs();
    almst_full_thr  = 5'd12;
    almst_empty_thr = 5'd3;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    n_reset = 1'b1;

    // Fill 0x1..0x10, then an overflowing 17th write
    for (int i = 1; i <= DEPTH; i++) do_write(64'(i));
    do_write(64'h99);
    idle_inputs(); cycle();

    // Drain all 16 in order
    for (int i = 0; i < DEPTH; i++) do_read();
    idle_inputs(); cycle();

    // Underflow, err_clr losing to a same-cycle underflow, then a plain clear
    do_read();
    idle_inputs(); rd_en = 1'b1; err_clr = 1'b1; cycle();
    idle_inputs(); err_clr = 1'b1; cycle();

    // Hold 8 entries with simultaneous read/write across the pointer wrap
    for (int i = 0; i < 8; i++) do_write({$urandom, $urandom});
    for (int i = 0; i < 40; i++) begin
      idle_inputs(); wr_en = 1'b1; rd_en = 1'b1; data_in = {$urandom, $urandom}; cycle();
    end

    // Threshold sweep from empty to full, then an unreachable almost-full level
    idle_inputs(); flush = 1'b1; cycle();
    for (int i = 0; i < DEPTH; i++) do_write({$urandom, $urandom});
    almst_full_thr = 5'd17;
    idle_inputs(); cycle();
    almst_full_thr = 5'd12;

    // Flush at count 9 with a concurrent write that must be ignored
    idle_inputs(); flush = 1'b1; cycle();
    for (int i = 0; i < 9; i++) do_write({$urandom, $urandom});
    idle_inputs(); flush = 1'b1; wr_en = 1'b1; data_in = 64'hDEAD; cycle();
    do_read();
    for (int i = 0; i < 5; i++) do_write(64'(100 + i));

    // Asynchronous reset mid-write, observed between clock edges
    idle_inputs(); wr_en = 1'b1; data_in = 64'h1234;
    #2;
    n_reset = 1'b0;
    #1;
    check("rst_count",    64'(data_count), 64'd0);
    check("rst_empty",    64'(empty),      64'd1);
    check("rst_full",     64'(full),       64'd0);
    check("rst_udf",      64'(udf_err),    64'd0);
    check("rst_ovf",      64'(ovf_err),    64'd0);
    check("rst_data_out", data_out,        64'd0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    n_reset = 1'b1;
    #1;
    check_outputs();
    @(posedge clk);
    #1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      wr_en   = ($urandom_range(0, 99) < 55);
      rd_en   = ($urandom_range(0, 99) < 50);
      flush   = ($urandom_range(0, 99) < 3);
      err_clr = ($urandom_range(0, 99) < 10);
      data_in = {$urandom, $urandom};
      if ($urandom_range(0, 19) == 0) begin
        almst_full_thr  = 5'($urandom_range(0, 31));
        almst_empty_thr = 5'($urandom_range(0, 31));
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_gen.md
# sync_fifo_gen

Parametrised single-clock FIFO, successor to the team's fixed-depth buffer, used between the Ascon datapath stages (plaintext/AD ingest, ciphertext/tag egress). It adds:
- power-of-two depth with wrap-bit pointers, so all entries are usable;
- run-time almost-full/almost-empty thresholds;
- synchronous flush;
- separate sticky overflow/underflow flags;
- compile-time choice of first-word-fall-through read.

## Interface
- DATA_W, 64, word width (one Ascon state word)
- ADDR_W, 4, address width; depth DEPTH = 2**ADDR_W
- clk  in  1  rising-edge clock
- n_reset  in  1  asynchronous, active-low reset
- data_in  in  DATA_W  write data
- wr_en  in  1  write request
- rd_en  in  1  read request
- flush  in  1  synchronous empty-the-FIFO
- err_clr  in  1  clears sticky error flags
- almst_full_thr  in  ADDR_W+1  almost-full threshold
- almst_empty_thr  in  ADDR_W+1  almost-empty threshold
- data_out  out  DATA_W  read data
- data_count  out  ADDR_W+1  occupancy, 0..DEPTH
- empty, full  out  1  occupancy flags
- almst_empty, almst_full  out  1  threshold flags
- ovf_err, udf_err  out  1  sticky overflow / underflow

## Operation
- Pointers wr_ptr/rd_ptr are ADDR_W+1 bits; low ADDR_W bits address storage; MSB is the wrap bit.
- Storage and count:
  - data_count = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
  - empty = (data_count == 0); full = (data_count == DEPTH).
- Access rules:
  - Write accepted iff wr_en && !full; read accepted iff rd_en && !empty. Acceptance is judged on registered state only.
  - Simultaneous wr_en/rd_en when neither flag blocks: both accepted, count unchanged.
  - Both asserted when full: read accepted, write rejected, ovf_err set.
  - Both asserted when empty: write accepted, read rejected, udf_err set. No pass-through.
- Threshold flags:
  - almst_full = (data_count >= almst_full_thr).
  - almst_empty = (data_count <= almst_empty_thr).
  - Thresholds are sampled live; values above DEPTH are legal (almst_full then never asserts).
- flush:
  - Sets both pointers to 0 next edge and overrides wr_en/rd_en that cycle.
  - No error is flagged during flush. Storage contents are not cleared.
  - data_out holds its value in registered mode; it is 0 in FWFT mode.
- Error flags:
  - Set on rejected wr_en (ovf_err) or rejected rd_en (udf_err).
  - Cleared by err_clr; set wins over clear in the same cycle.
  - flush does not clear them.
- Reset (asynchronous, any time, including mid-burst):
  - Pointers 0, data_count 0, empty 1, full 0.
  - almst_* follow the threshold compare against count 0.
  - ovf_err 0, udf_err 0, data_out 0.

## Timing
- All state changes on the rising clk edge; reset asserts asynchronously and deasserts synchronously to clk outside this block.
- Status outputs are decoded from registers. There is no combinational path from wr_en/rd_en/flush to any output.
- Write-to-empty-deassert latency: 1 cycle.
- Full asserts the cycle after the DEPTH-th accepted write.
- Registered read mode: data_out loads mem[rd_ptr] on the edge of an accepted read, so it is valid 1 cycle after rd_en. It holds otherwise.
- FWFT mode: see Configuration.
- Pointer wrap from DEPTH-1 to 0 is seamless; the wrap bit toggles.

## Configuration
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out = mem[rd_ptr] whenever !empty, else 0; head word is visible in the cycle empty deasserts.
  - rd_en acknowledges the head word, so read latency is 0.
- Undefined: registered read mode as in Timing, with 1-cycle latency.
- Both modes share identical flag and error behaviour.

## Structure
- Package sync_fifo_pkg:
  - default DATA_W/ADDR_W localparams;
  - function clog2;
  - typedef for pointer width.
- One sub-module, sync_fifo_ram: DEPTH x DATA_W array, synchronous write port, asynchronous read port.
- Control, pointers, flags and errors live in sync_fifo_gen.

## Test plan
- Reset release, then 16 writes of 0x1..0x10 (ADDR_W=4):
  - empty drops after write 1; full rises after write 16; data_count=16;
  - a 17th write sets ovf_err and leaves contents intact.
- Read all 16: data_out sequence 0x1..0x10 (registered: one cycle after each rd_en; FWFT: head visible before rd_en); empty rises after read 16.
- Extra read on empty -> udf_err=1. Then err_clr together with another empty read -> udf_err stays 1. Then err_clr alone -> 0.
- Continuous wr_en&rd_en at 8 entries for 40 cycles across pointer wrap -> data_count constant 8, data ordering preserved.
- almst_full_thr=12, almst_empty_thr=3:
  - fill 0->16: almst_empty deasserts at count 4; almst_full asserts at count 12.
  - thr=17: almst_full never asserts.
- Mid-burst: flush at count 9 -> count 0 next cycle, simultaneous wr_en ignored. n_reset pulsed asynchronously mid-write -> all outputs at reset values without waiting for a clock edge.
